// File: rtl/tea_decrypt_core.sv
// Iterative TEA block decryptor: one half-round per clock (RND_A updates v1, RND_B updates v0).
// Ready/valid on both sides; plaintext is held in DONE until the consumer takes it.
module tea_decrypt_core #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9e3779b9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_v0,
  input  logic [31:0]  in_v1,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_v0,
  output logic [31:0]  out_v1,
  output logic         busy
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [W-1:0]  SUM_INIT = W'(64'(DELTA) * 64'(ROUNDS));
  localparam logic [CW-1:0] CNT_INIT = CW'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RND_A = 2'd1,
    RND_B = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  v0_q, v0_d, v1_q, v1_d;
  logic [W-1:0]  k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  // TEA mixing function shared by both half-rounds
  function automatic logic [W-1:0] mix(input logic [W-1:0] x, input logic [W-1:0] ka,
                                       input logic [W-1:0] kb, input logic [W-1:0] s);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

  // State and datapath registers; reset wins over every handshake input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      v0_q        <= '0;
      v1_q        <= '0;
      k0_q        <= '0;
      k1_q        <= '0;
      k2_q        <= '0;
      k3_q        <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      k0_q        <= k0_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      k3_q        <= k3_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RND_A;
      RND_A:   state_d = RND_B;
      RND_B:   state_d = (cnt_q == CW'(1)) ? DONE : RND_A;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one half-round per state
  always_comb begin
    v0_d  = v0_q;
    v1_d  = v1_q;
    k0_d  = k0_q;
    k1_d  = k1_q;
    k2_d  = k2_q;
    k3_d  = k3_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          v0_d  = in_v0;
          v1_d  = in_v1;
          k0_d  = key[127:96];
          k1_d  = key[95:64];
          k2_d  = key[63:32];
          k3_d  = key[31:0];
          sum_d = SUM_INIT;
          cnt_d = CNT_INIT;
        end
      end
      RND_A: v1_d = v1_q - mix(v0_q, k2_q, k3_q, sum_q);
      RND_B: begin
        v0_d  = v0_q - mix(v1_q, k0_q, k1_q, sum_q);
        sum_d = sum_q - DELTA;
        cnt_d = cnt_q - CW'(1);
      end
      default: ;
    endcase
  end

  // Status outputs registered from the next state so they track the state exactly
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_v0    = v0_q;
  assign out_v1    = v1_q;

endmodule

// File: tb/tb_tea_decrypt_core.sv
// Self-checking bench for tea_decrypt_core: known answers, backpressure, mid-run reset,
// input isolation, random round-trips against a software TEA model, and a 1-round core.
module tb_tea_decrypt_core;

  localparam int unsigned R     = 32;
  localparam logic [31:0] DELTA = 32'h9e3779b9;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0]  in_v0, in_v1, out_v0, out_v1;
  logic [127:0] key;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [31:0]  in_v0_1, in_v1_1, out_v0_1, out_v1_1;
  logic [127:0] key1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tea_decrypt_core #(.ROUNDS(R), .DELTA(DELTA)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_v0(in_v0), .in_v1(in_v1), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .out_v0(out_v0), .out_v1(out_v1), .busy(busy)
  );

  tea_decrypt_core #(.ROUNDS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_v0(in_v0_1), .in_v1(in_v1_1), .key(key1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_v0(out_v0_1), .out_v1(out_v1_1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference TEA (textbook loop form)
  function automatic logic [63:0] tea_enc(input int unsigned n, input logic [63:0] blk,
                                          input logic [127:0] k);
    logic [31:0] a, b, s;
    a = blk[63:32]; b = blk[31:0]; s = 32'd0;
    for (int i = 0; i < int'(n); i++) begin
      s = s + DELTA;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] tea_dec(input int unsigned n, input logic [63:0] blk,
                                          input logic [127:0] k);
    logic [31:0] a, b, s;
    a = blk[63:32]; b = blk[31:0]; s = 32'd0;
    for (int i = 0; i < int'(n); i++) s = s + DELTA;
    for (int i = 0; i < int'(n); i++) begin
      b = b - (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
      a = a - (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      s = s - DELTA;
    end
    return {a, b};
  endfunction

  // One block through the main core; optional input scrambling and DONE backpressure
  task automatic run_block(input string tag, input logic [63:0] blk, input logic [127:0] k,
                           input bit scramble, input bit bp);
    int w;
    int lat;
    logic [63:0] exp;
    exp = tea_dec(R, blk, k);
    w = 0;
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, 64'(in_ready), 64'(1));
    in_v0 = blk[63:32]; in_v1 = blk[31:0]; key = k;
    in_valid = 1'b1;
    out_ready = !bp;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      if (scramble) begin
        in_v0 = $urandom; in_v1 = $urandom;
        key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(2 * R));
    chk({tag, "_data"}, {out_v0, out_v1}, exp);
    chk({tag, "_sum"}, 64'(dut.sum_q), 64'(0));
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        in_v0 = $urandom; in_v1 = $urandom;
        key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk({tag, "_bp_data"}, {out_v0, out_v1}, exp);
        chk({tag, "_bp_hs"}, {62'(0), in_ready, out_valid}, 64'(1));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_bp_release"}, {61'(0), in_ready, out_valid, busy}, 64'(3'b100));
      chk({tag, "_bp_hold"}, {out_v0, out_v1}, exp);
    end else begin
      @(negedge clk);
      chk({tag, "_idle"}, {61'(0), in_ready, out_valid, busy}, 64'(3'b100));
    end
  endtask

  logic [63:0]  pt [256];
  logic [63:0]  ct [256];
  logic [127:0] kk [256];

  initial begin
    int sent, recv, cyc, last_acc, seen, lat;
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_v0 = 32'hdeadbeef; in_v1 = 32'h12345678; key = '1;
    in_valid1 = 1'b1; out_ready1 = 1'b1; in_v0_1 = '0; in_v1_1 = '0; key1 = '0;

    // Reset with in_valid asserted: reset must win
    repeat (3) @(negedge clk);
    chk("rst_hs", {61'(0), in_ready, out_valid, busy}, 64'(3'b100));
    chk("rst_data", {out_v0, out_v1}, 64'(0));
    chk("rst_hs1", {61'(0), in_ready1, out_valid1, busy1}, 64'(3'b100));
    in_valid = 1'b0; in_valid1 = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_hold", {61'(0), in_ready, out_valid, busy}, 64'(3'b100));

    // Known answer, then known answer under backpressure
    run_block("kat", {32'h41ea3a0a, 32'h94baa940}, 128'h0, 1'b0, 1'b0);
    chk("kat_const", {out_v0, out_v1}, 64'(0));
    run_block("bp", {32'h41ea3a0a, 32'h94baa940}, 128'h0, 1'b0, 1'b1);

    // Input isolation while scrambling inputs every cycle
    run_block("iso", {32'h41ea3a0a, 32'h94baa940}, 128'h0, 1'b1, 1'b0);
    chk("iso_const", {out_v0, out_v1}, 64'(0));

    // Mid-run reset around round 10
    in_v0 = 32'h41ea3a0a; in_v1 = 32'h94baa940; key = '0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_hs", {61'(0), in_ready, out_valid, busy}, 64'(3'b100));
    chk("mid_data", {out_v0, out_v1}, 64'(0));
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_no_valid", 64'(seen), 64'(0));
    run_block("post_rst", {32'h41ea3a0a, 32'h94baa940}, 128'h0, 1'b0, 1'b0);
    chk("post_rst_const", {out_v0, out_v1}, 64'(0));

    // Random round-trips, back-to-back
    for (int i = 0; i < 256; i++) begin
      pt[i] = {$urandom, $urandom};
      kk[i] = {$urandom, $urandom, $urandom, $urandom};
      ct[i] = tea_enc(R, pt[i], kk[i]);
    end
    sent = 0; recv = 0; cyc = 0; last_acc = -1;
    out_ready = 1'b1; in_valid = 1'b0;
    while (recv < 256 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("rt_data", {out_v0, out_v1}, pt[recv]);
        recv++;
      end
      if (in_ready && sent < 256) begin
        if (last_acc >= 0) chk("rt_gap", 64'(cyc - last_acc - 1), 64'(2 * R + 1));
        last_acc = cyc;
        in_v0 = ct[sent][63:32]; in_v1 = ct[sent][31:0]; key = kk[sent];
        in_valid = 1'b1;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("rt_count", 64'(recv), 64'(256));

    // Single-round core
    in_v0_1 = '0; in_v1_1 = '0; key1 = '0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin @(negedge clk); lat++; end
    chk("r1_latency", 64'(lat), 64'(2));
    chk("r1_data", {out_v0_1, out_v1_1}, tea_dec(1, 64'(0), 128'h0));
    chk("r1_sum", 64'(dut1.sum_q), 64'(0));
    @(negedge clk);
    chk("r1_idle", {61'(0), in_ready1, out_valid1, busy1}, 64'(3'b100));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tea_decrypt_core.md
TEA_DECRYPT_CORE -- requirements
Module: tea_decrypt_core

Interface
REQ-001 Parameter ROUNDS, default 32, SHALL set the number of TEA rounds; legal range is 1..63.
REQ-002 Parameter DELTA, default 32'h9e3779b9, SHALL set the key-schedule constant.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 in_valid  in  1  SHALL indicate that the ciphertext block and key on the inputs are valid.
REQ-006 in_ready  out  1  SHALL indicate that the core can accept a block.
REQ-007 in_v0, in_v1  in  32 each  SHALL carry the ciphertext words.
REQ-008 key  in  128  SHALL carry the key, split as k0=key[127:96], k1=key[95:64], k2=key[63:32], k3=key[31:0].
REQ-009 out_valid  out  1  SHALL indicate that the plaintext on out_v0/out_v1 is valid.
REQ-010 out_ready  in  1  SHALL indicate that the downstream consumer accepts the plaintext.
REQ-011 out_v0, out_v1  out  32 each  SHALL carry the plaintext words.
REQ-012 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RND_A, RND_B and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 On accept (IDLE and in_valid) the core SHALL:
  - latch in_v0/in_v1 into v0/v1;
  - latch the key into k0..k3;
  - load sum = DELTA*ROUNDS mod 2^32 (32'hC6EF3720 for the defaults);
  - load round counter = ROUNDS;
  - go to RND_A.
REQ-016 In IDLE with in_valid low, the core SHALL stay in IDLE and leave all registers unchanged.
REQ-017 RND_A SHALL do v1 <= v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)), then go to RND_B.
REQ-018 RND_B SHALL do the following, then go to DONE if the pre-decrement counter was 1, else to RND_A:
  - v0 <= v0 - (((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)), using the v1 updated in RND_A;
  - sum <= sum - DELTA;
  - counter decrements by 1.
REQ-019 All arithmetic SHALL be unsigned modulo 2^32.
REQ-020 Shifts SHALL be logical; bits shifted past bit 31 are dropped and >>5 zero-fills.
REQ-021 Latency SHALL be exactly 2*ROUNDS cycles from the accepting edge to the first cycle with out_valid=1 (64 cycles for the defaults).
REQ-022 out_v0/out_v1 SHALL be driven directly from v0/v1.
REQ-023 In DONE, out_v0/out_v1 SHALL stay stable while out_ready is low.
REQ-024 In DONE, when out_ready=1, the core SHALL return to IDLE on that edge; in_ready rises the following cycle (no same-cycle bypass).
REQ-025 In DONE the core SHALL ignore in_valid and leave the latched key unchanged.
REQ-026 Changes to in_v0/in_v1/key after accept SHALL NOT affect the block in progress.
REQ-027 After the final RND_B, sum SHALL equal 0.

Reset
REQ-028 While reset=1 at a clock edge, the core SHALL force:
  - state IDLE;
  - v0, v1, k0..k3, sum and counter to 0;
  - out_valid 0, busy 0, in_ready 1 from the next cycle.
REQ-029 Reset SHALL abort any block in progress, including in RND_A, RND_B or DONE; no out_valid SHALL follow for an aborted block.
REQ-030 Reset SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-031 Known-answer test: key=0, in_v0=32'h41ea3a0a, in_v1=32'h94baa940 -> out_v0=0, out_v1=0, with out_valid rising exactly 64 cycles after accept.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 and a new in_valid ignored; on out_ready=1 -> IDLE, then in_ready=1 one cycle later.
REQ-033 Mid-run reset: assert reset at round 10 -> next cycle busy=0, out_valid=0, out_v0=out_v1=0; a subsequent known-answer block still decrypts correctly.
REQ-034 Round-trip: encrypt 256 random blocks/keys with a software TEA model, feed back-to-back with out_ready=1 -> every output equals the original plaintext, with 2*ROUNDS+1 cycles between accepts.
REQ-035 ROUNDS=1, DELTA default: key=128'h0, block (0,0) -> outputs match a 1-round software model; latency 2 cycles; final sum 0.
REQ-036 Input-change isolation: alter in_v0/in_v1/key every cycle after accept -> output identical to REQ-031.
